// File: rtl/text_mode_scanout.sv
`default_nettype none
// ============================================================================
// Module   : text_mode_scanout
// Purpose  : VGA text-mode scan-out with a text RAM fetch, a font ROM lookup,
//            a blinking block cursor, inverse video and a frame-start strobe.
// Revision : 1.0 - initial release
// ============================================================================
module text_mode_scanout #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int ADDR_W       = 11,
    parameter int SYNC_POL     = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                       i_clk_vga,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_invert,
    input  logic                       i_cursor_en,
    input  logic [ADDR_W-1:0]          i_cursor_addr,
    output logic                       o_text_re,
    output logic [ADDR_W-1:0]          o_text_addr,
    input  logic [7:0]                 i_text_data,
    output logic [7:0]                 o_glyph_code,
    output logic [$clog2(GLYPH_H)-1:0] o_glyph_row,
    input  logic [GLYPH_W-1:0]         i_glyph_bits,
    output logic                       o_pixel,
    output logic                       o_hsync,
    output logic                       o_vsync,
    output logic                       o_frame_start
);

    localparam int   c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   c_COLS     = H_ACTIVE / GLYPH_W;
    localparam int   c_ROWS     = V_ACTIVE / GLYPH_H;
    localparam int   c_CELLS    = c_COLS * c_ROWS;
    localparam int   c_HW       = $clog2(c_H_TOTAL);
    localparam int   c_VW       = $clog2(c_V_TOTAL);
    localparam int   c_GW_LOG   = $clog2(GLYPH_W);
    localparam int   c_GH_LOG   = $clog2(GLYPH_H);
    localparam int   c_BW       = $clog2(BLINK_FRAMES + 1);
    localparam logic c_SYNC_ACT = (SYNC_POL != 0);

    logic [c_HW-1:0]     r_h_cnt;
    logic [c_VW-1:0]     r_v_cnt;
    logic                r_started;
    logic [ADDR_W-1:0]   r_line_base;
    logic                r_enable_l;
    logic                r_invert_l;
    logic                r_cursor_en_l;
    logic [ADDR_W-1:0]   r_cursor_addr_l;
    logic [c_BW-1:0]     r_blink_cnt;
    logic                r_phase;
    logic                r_re_d1;
    logic                r_re_d2;
    logic                r_hit_d1;
    logic                r_hit_d2;
    logic [c_GH_LOG-1:0] r_row_d1;
    logic [GLYPH_W-1:0]  r_shift;
    logic                r_cell_hit;
    logic [2:0]          r_vis_d;
    logic [2:0]          r_hs_d;
    logic [2:0]          r_vs_d;

    logic                w_h_last;
    logic                w_v_last;
    logic                w_active_line;
    logic                w_active;
    logic                w_hs;
    logic                w_vs;
    logic                w_enable;
    logic                w_cursor_en;
    logic [ADDR_W-1:0]   w_cursor_addr;
    logic [ADDR_W-1:0]   w_text_addr;
    logic                w_fetch;
    logic                w_hit;

    assign w_h_last      = (r_h_cnt == c_HW'(c_H_TOTAL - 1));
    assign w_v_last      = (r_v_cnt == c_VW'(c_V_TOTAL - 1));
    assign w_active_line = (int'(r_v_cnt) < V_ACTIVE);
    assign w_active      = (int'(r_h_cnt) < H_ACTIVE) && w_active_line;
    assign w_hs = ((int'(r_h_cnt) >= H_ACTIVE + H_FP) && (int'(r_h_cnt) < H_ACTIVE + H_FP + H_SYNC))
                  ? c_SYNC_ACT : ~c_SYNC_ACT;
    assign w_vs = ((int'(r_v_cnt) >= V_ACTIVE + V_FP) && (int'(r_v_cnt) < V_ACTIVE + V_FP + V_SYNC))
                  ? c_SYNC_ACT : ~c_SYNC_ACT;

    // r_started holds the counters for one cycle after reset so frame 0 gets its own pulse.
    assign o_frame_start = r_started && (r_h_cnt == '0) && (r_v_cnt == '0);

    // The cell at the frame origin is fetched in the latching cycle, so use the live inputs there.
    assign w_enable      = o_frame_start ? i_enable      : r_enable_l;
    assign w_cursor_en   = o_frame_start ? i_cursor_en   : r_cursor_en_l;
    assign w_cursor_addr = o_frame_start ? i_cursor_addr : r_cursor_addr_l;

    assign w_text_addr = r_line_base + ADDR_W'(r_h_cnt >> c_GW_LOG);
    assign w_fetch     = w_active && w_enable && (r_h_cnt[c_GW_LOG-1:0] == '0);
    assign w_hit       = w_cursor_en && (w_text_addr == w_cursor_addr) && (int'(w_cursor_addr) < c_CELLS);

    assign o_text_re   = w_fetch;
    assign o_text_addr = w_text_addr;
    assign o_pixel     = r_vis_d[2] & (r_shift[GLYPH_W-1] ^ (r_cell_hit & r_phase) ^ r_invert_l);
    assign o_hsync     = r_hs_d[2];
    assign o_vsync     = r_vs_d[2];

    always_ff @(posedge i_clk_vga or posedge i_reset) begin
        if (i_reset) begin
            r_h_cnt         <= '0;
            r_v_cnt         <= '0;
            r_started       <= 1'b0;
            r_line_base     <= '0;
            r_enable_l      <= 1'b0;
            r_invert_l      <= 1'b0;
            r_cursor_en_l   <= 1'b0;
            r_cursor_addr_l <= '0;
            r_blink_cnt     <= '0;
            r_phase         <= 1'b1;
        end else begin
            r_started <= 1'b1;
            if (r_started) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + c_VW'(1);
                    if (int'(r_v_cnt) == V_ACTIVE - 1) begin
                        r_line_base <= '0;
                    end else if (w_active_line && (r_v_cnt[c_GH_LOG-1:0] == '1)) begin
                        r_line_base <= r_line_base + ADDR_W'(c_COLS);
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + c_HW'(1);
                end
            end
            if (o_frame_start) begin
                r_enable_l      <= i_enable;
                r_invert_l      <= i_invert;
                r_cursor_en_l   <= i_cursor_en;
                r_cursor_addr_l <= i_cursor_addr;
                // The toggling pulse is also the first frame of the new half-period.
                if (r_blink_cnt == c_BW'(BLINK_FRAMES)) begin
                    r_blink_cnt <= c_BW'(1);
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_BW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk_vga or posedge i_reset) begin
        if (i_reset) begin
            r_re_d1      <= 1'b0;
            r_re_d2      <= 1'b0;
            r_hit_d1     <= 1'b0;
            r_hit_d2     <= 1'b0;
            r_row_d1     <= '0;
            o_glyph_code <= '0;
            o_glyph_row  <= '0;
            r_shift      <= '0;
            r_cell_hit   <= 1'b0;
            r_vis_d      <= '0;
            r_hs_d       <= {3{~c_SYNC_ACT}};
            r_vs_d       <= {3{~c_SYNC_ACT}};
        end else begin
            r_re_d1  <= w_fetch;
            r_re_d2  <= r_re_d1;
            r_hit_d1 <= w_hit;
            r_hit_d2 <= r_hit_d1;
            r_row_d1 <= r_v_cnt[c_GH_LOG-1:0];
            if (r_re_d1) begin
                o_glyph_code <= i_text_data;
                o_glyph_row  <= r_row_d1;
            end
            if (r_re_d2) begin
                r_shift    <= i_glyph_bits;
                r_cell_hit <= r_hit_d2;
            end else begin
                r_shift <= {r_shift[GLYPH_W-2:0], 1'b0};
            end
            r_vis_d <= {r_vis_d[1:0], w_active && w_enable};
            r_hs_d  <= {r_hs_d[1:0], w_hs};
            r_vs_d  <= {r_vs_d[1:0], w_vs};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_mode_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_mode_scanout
// Purpose  : Self-checking bench for text_mode_scanout on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_mode_scanout;

    localparam int HA = 32, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 16, VFP = 2, VSY = 2, VBP = 2;
    localparam int GW = 8, GH = 4, AW = 5, BLINK = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int COLS = HA / GW, CELLS = COLS * (VA / GH);
    localparam int FRAME = HT * VT;
    localparam int PIPE = 3;
    localparam int NF = 9;

    typedef struct {
        logic          en;
        logic          inv;
        logic          cen;
        logic [AW-1:0] ca;
        int            fetches;
        logic          phase;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          d_en, d_inv, d_cen;
    logic [AW-1:0] d_ca;
    logic          text_re;
    logic [AW-1:0] text_addr;
    logic [7:0]    text_data = 8'h00;
    logic [7:0]    glyph_code;
    logic [1:0]    glyph_row;
    logic [7:0]    glyph_bits;
    logic          pixel, hsync, vsync, frame_start;

    logic [7:0] ram [32];
    vec_t       tbl [NF];
    logic [7:0] sb [$];

    int   n_tests = 0, n_fail = 0;
    int   mh, mv, fnum, cyc, f_cnt, stray;
    logic m_en, m_inv, m_cen, m_phase;
    int   m_ca;
    logic [7:0] acc;
    logic prev_hs, prev_vs, hs_seen, vs_seen;
    int   last_hs, last_vs;
    logic found, at_target;

    text_mode_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .GLYPH_W(GW), .GLYPH_H(GH), .ADDR_W(AW), .SYNC_POL(0), .BLINK_FRAMES(BLINK)
    ) u_dut (
        .i_clk_vga(clk), .i_reset(rst), .i_enable(d_en), .i_invert(d_inv),
        .i_cursor_en(d_cen), .i_cursor_addr(d_ca),
        .o_text_re(text_re), .o_text_addr(text_addr), .i_text_data(text_data),
        .o_glyph_code(glyph_code), .o_glyph_row(glyph_row), .i_glyph_bits(glyph_bits),
        .o_pixel(pixel), .o_hsync(hsync), .o_vsync(vsync), .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] font(input logic [7:0] c, input logic [1:0] r);
        if (c == 8'h41 && r == 2'd0) return 8'b1000_0001;
        return c ^ {r, ~r, r, ~r};
    endfunction

    assign glyph_bits = font(glyph_code, glyph_row);

    always @(posedge clk) if (text_re) text_data <= ram[text_addr];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at frame %0d v %0d h %0d",
                     name, act, act, exp, exp, fnum, mv, mh);
        end
    endtask

    task automatic drive(input vec_t v);
        d_en = v.en; d_inv = v.inv; d_cen = v.cen; d_ca = v.ca;
    endtask

    // Called once per cycle at the falling edge, with (mh, mv) naming the current DUT cycle.
    task automatic process();
        logic       fs_exp, hit;
        logic [7:0] bits, exp_byte;
        int         addr;
        fs_exp = (mh == 0 && mv == 0);
        if (fs_exp) begin
            fnum++;
            m_en = d_en; m_inv = d_inv; m_cen = d_cen; m_ca = int'(d_ca);
            m_phase = tbl[(fnum < NF) ? fnum : NF - 1].phase;
            f_cnt = 0; stray = 0;
        end
        if (frame_start || fs_exp) check("frame_start", int'(frame_start), int'(fs_exp));
        f_cnt += int'(text_re);
        if (m_en && mh < HA && mv < VA && (mh % GW) == 0) begin
            addr = (mv / GH) * COLS + mh / GW;
            check("text_re", int'(text_re), 1);
            check("text_addr", int'(text_addr), addr);
            bits = font(ram[addr], 2'(mv % GH));
            hit = m_cen && (m_ca == addr) && (m_ca < CELLS);
            exp_byte = bits ^ {8{hit & m_phase}} ^ {8{m_inv}};
            sb.push_back(exp_byte);
        end
        if (m_en && mv < VA && mh >= PIPE && mh < HA + PIPE) begin
            acc = {acc[6:0], pixel};
            if (((mh - PIPE) % GW) == GW - 1) begin
                if (sb.size() == 0) check("scoreboard_underflow", 1, 0);
                else check("pixel_byte", int'(acc), int'(sb.pop_front()));
            end
        end else if (pixel) begin
            stray++;
        end
        if (prev_hs && !hsync) begin
            check("hsync_fall_pos", mh, (HA + HFP + PIPE) % HT);
            if (hs_seen) check("hsync_period", cyc - last_hs, HT);
            last_hs = cyc; hs_seen = 1'b1;
        end
        if (!prev_hs && hsync && hs_seen) check("hsync_width", cyc - last_hs, HSY);
        if (prev_vs && !vsync) begin
            check("vsync_fall_pos", mv * HT + mh, (VA + VFP) * HT + PIPE);
            if (vs_seen) check("vsync_period", cyc - last_vs, FRAME);
            last_vs = cyc; vs_seen = 1'b1;
        end
        if (!prev_vs && vsync && vs_seen) check("vsync_width", cyc - last_vs, VSY * HT);
        prev_hs = hsync; prev_vs = vsync;
        if (mh == HT - 1 && mv == VT - 1 && fnum < NF) begin
            check("fetch_count", f_cnt, tbl[fnum].fetches);
            check("blank_pixels", stray, 0);
        end
        // Mid-frame changes must be ignored until the next frame start.
        if (mh == 0 && mv == 8) begin
            d_en = ~d_en; d_inv = ~d_inv; d_cen = ~d_cen; d_ca = d_ca ^ 5'd1;
        end
        if (mh == 0 && mv == VT - 1 && fnum + 1 < NF) drive(tbl[fnum + 1]);
        cyc++;
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'((i * 29 + 7) % 256);
        ram[0] = 8'h41;
        //         en    inv   cen   ca     fetches phase
        tbl[0] = '{1'b1, 1'b0, 1'b1, 5'd5,  64, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 5'd5,  64, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 5'd5,  64, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 5'd5,  64, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 5'd20, 64, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 5'd5,  0,  1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 5'd5,  64, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 5'd15, 64, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 5'd0,  64, 1'b1};
        drive(tbl[0]);
        fnum = -1; cyc = 0; f_cnt = 0; stray = 0; acc = 8'h00;
        m_en = 1'b0; m_inv = 1'b0; m_cen = 1'b0; m_phase = 1'b1; m_ca = 0;
        mh = 0; mv = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; hs_seen = 1'b0; vs_seen = 1'b0;
        last_hs = 0; last_vs = 0;

        repeat (3) @(negedge clk);
        check("rst_text_re", int'(text_re), 0);
        check("rst_text_addr", int'(text_addr), 0);
        check("rst_pixel", int'(pixel), 0);
        check("rst_glyph_code", int'(glyph_code), 0);
        check("rst_glyph_row", int'(glyph_row), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_frame_start", int'(frame_start), 0);
        rst = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            found = frame_start;
        end
        check("first_frame_start", int'(found), 1);
        if (!found) begin
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end

        process();
        for (int c = 1; c < 8 * FRAME; c++) begin
            @(negedge clk);
            process();
        end
        check("scoreboard_drained", sb.size(), 0);

        // Reset in the middle of an active line of frame 8.
        at_target = 1'b0;
        for (int i = 0; i < FRAME && !at_target; i++) begin
            @(negedge clk);
            at_target = (mh == 30 && mv == 2);
            process();
        end
        check("reached_reset_point", int'(at_target), 1);
        check("pre_reset_addr", int'(text_addr), 3);
        rst = 1'b1;
        #1;
        check("midrst_text_re", int'(text_re), 0);
        check("midrst_text_addr", int'(text_addr), 0);
        check("midrst_pixel", int'(pixel), 0);
        check("midrst_glyph_code", int'(glyph_code), 0);
        check("midrst_glyph_row", int'(glyph_row), 0);
        check("midrst_hsync", int'(hsync), 1);
        check("midrst_vsync", int'(vsync), 1);
        check("midrst_frame_start", int'(frame_start), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            found = frame_start;
        end
        check("post_rst_frame_start", int'(found), 1);
        check("post_rst_text_re", int'(text_re), 1);
        check("post_rst_text_addr", int'(text_addr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
